// File: rtl/ddr3_fifo_servicer.sv
// Drains write-back and refill-request FIFOs into single-beat DDR3 application commands,
// one command in flight at a time, write-backs first; refill data goes to the read-out FIFO.
module ddr3_fifo_servicer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_fifo_empty,
    input  logic [ADDR_WIDTH-1:0] write_fifo_address,
    input  logic [DATA_WIDTH-1:0] write_fifo_data,
    output logic                  read_from_write_fifo,
    input  logic                  read_in_fifo_empty,
    input  logic [ADDR_WIDTH-1:0] read_in_fifo_address,
    output logic                  read_from_read_in_fifo,
    input  logic                  read_out_fifo_full,
    output logic                  write_into_read_out_fifo,
    output logic [DATA_WIDTH-1:0] read_out_fifo_write_data,
    output logic                  app_cmd_valid,
    output logic                  app_cmd_write,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [DATA_WIDTH-1:0] app_wdata,
    input  logic                  app_ready,
    input  logic                  app_rdata_valid,
    input  logic [DATA_WIDTH-1:0] app_rdata,
    output logic                  busy,
    output logic                  timeout_error
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
    // Lines are 16 bytes, so the low nibble of every command address is cleared.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(4'hF);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_WAIT,
        RD_PUSH
    } state_t;

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] timeout_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg                <= IDLE;
            timeout_cnt_reg          <= '0;
            read_from_write_fifo     <= 1'b0;
            read_from_read_in_fifo   <= 1'b0;
            write_into_read_out_fifo <= 1'b0;
            read_out_fifo_write_data <= '0;
            app_cmd_valid            <= 1'b0;
            app_cmd_write            <= 1'b0;
            app_addr                 <= '0;
            app_wdata                <= '0;
            busy                     <= 1'b0;
            timeout_error            <= 1'b0;
        end else begin
            read_from_write_fifo     <= 1'b0;
            read_from_read_in_fifo   <= 1'b0;
            write_into_read_out_fifo <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Write-backs win so a dirty line reaches memory before its refill.
                    if (!write_fifo_empty) begin
                        app_addr             <= write_fifo_address & LINE_MASK;
                        app_wdata            <= write_fifo_data;
                        app_cmd_write        <= 1'b1;
                        app_cmd_valid        <= 1'b1;
                        read_from_write_fifo <= 1'b1;
                        busy                 <= 1'b1;
                        state_reg            <= WR_CMD;
                    end else if (!read_in_fifo_empty && !read_out_fifo_full) begin
                        app_addr               <= read_in_fifo_address & LINE_MASK;
                        app_wdata              <= '0;
                        app_cmd_write          <= 1'b0;
                        app_cmd_valid          <= 1'b1;
                        read_from_read_in_fifo <= 1'b1;
                        busy                   <= 1'b1;
                        state_reg              <= RD_CMD;
                    end
                end

                WR_CMD: begin
                    if (app_ready) begin
                        app_cmd_valid <= 1'b0;
                        busy          <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                RD_CMD: begin
                    if (app_ready) begin
                        app_cmd_valid   <= 1'b0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (app_rdata_valid) begin
                        read_out_fifo_write_data <= app_rdata;
                        if (!read_out_fifo_full) begin
                            write_into_read_out_fifo <= 1'b1;
                            busy                     <= 1'b0;
                            state_reg                <= IDLE;
                        end else begin
                            state_reg <= RD_PUSH;
                        end
                    end else if (timeout_cnt_reg >= CNT_MAX) begin
                        // Abandon the refill; the flag stays set until reset.
                        timeout_error <= 1'b1;
                        busy          <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_WIDTH'(1);
                    end
                end

                RD_PUSH: begin
                    if (!read_out_fifo_full) begin
                        write_into_read_out_fifo <= 1'b1;
                        busy                     <= 1'b0;
                        state_reg                <= IDLE;
                    end
                end

                default: begin
                    app_cmd_valid <= 1'b0;
                    busy          <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_fifo_servicer.sv
// Scoreboard bench for ddr3_fifo_servicer: small FIFO models drive the inputs, expected
// commands and returned lines are queued at stimulus time and compared as the DUT emits them.
module tb_ddr3_fifo_servicer;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_fifo_empty = 1'b1;
    logic [AW-1:0] write_fifo_address = '0;
    logic [DW-1:0] write_fifo_data = '0;
    logic          read_from_write_fifo;
    logic          read_in_fifo_empty = 1'b1;
    logic [AW-1:0] read_in_fifo_address = '0;
    logic          read_from_read_in_fifo;
    logic          read_out_fifo_full = 1'b0;
    logic          write_into_read_out_fifo;
    logic [DW-1:0] read_out_fifo_write_data;
    logic          app_cmd_valid;
    logic          app_cmd_write;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdata;
    logic          app_ready = 1'b0;
    logic          app_rdata_valid = 1'b0;
    logic [DW-1:0] app_rdata = '0;
    logic          busy;
    logic          timeout_error;

    ddr3_fifo_servicer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .write_fifo_empty        (write_fifo_empty),
        .write_fifo_address      (write_fifo_address),
        .write_fifo_data         (write_fifo_data),
        .read_from_write_fifo    (read_from_write_fifo),
        .read_in_fifo_empty      (read_in_fifo_empty),
        .read_in_fifo_address    (read_in_fifo_address),
        .read_from_read_in_fifo  (read_from_read_in_fifo),
        .read_out_fifo_full      (read_out_fifo_full),
        .write_into_read_out_fifo(write_into_read_out_fifo),
        .read_out_fifo_write_data(read_out_fifo_write_data),
        .app_cmd_valid           (app_cmd_valid),
        .app_cmd_write           (app_cmd_write),
        .app_addr                (app_addr),
        .app_wdata               (app_wdata),
        .app_ready               (app_ready),
        .app_rdata_valid         (app_rdata_valid),
        .app_rdata               (app_rdata),
        .busy                    (busy),
        .timeout_error           (timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t          exp_cmd[$];
    logic [DW-1:0] exp_push[$];

    logic [AW-1:0] wf_addr[16];
    logic [DW-1:0] wf_data[16];
    logic [AW-1:0] rf_addr[16];
    int wf_head = 0, wf_tail = 0, rf_head = 0, rf_tail = 0;

    int checks = 0, errors = 0;
    int cyc = 0, wr_pops = 0, rd_pops = 0, pushes = 0, valid_cycles = 0, busy_cycles = 0;
    int last_push_cyc = -1;
    bit hs_seen = 0;

    task automatic add_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t e;
        wf_addr[wf_tail % 16] = a;
        wf_data[wf_tail % 16] = d;
        wf_tail++;
        e.w = 1'b1; e.a = {a[AW-1:4], 4'h0}; e.d = d;
        exp_cmd.push_back(e);
    endtask

    task automatic add_read(input logic [AW-1:0] a);
        cmd_t e;
        rf_addr[rf_tail % 16] = a;
        rf_tail++;
        e.w = 1'b0; e.a = {a[AW-1:4], 4'h0}; e.d = '0;
        exp_cmd.push_back(e);
    endtask

    // One clock cycle: sample outputs at negedge, run FIFO models and scoreboard, return at posedge+1.
    task automatic step();
        @(negedge clk);
        cyc++;
        hs_seen = 0;
        if (read_from_write_fifo) begin wr_pops++; wf_head++; end
        if (read_from_read_in_fifo) begin rd_pops++; rf_head++; end
        if (busy) busy_cycles++;
        if (app_cmd_valid) valid_cycles++;
        if (app_cmd_valid && app_ready) begin
            hs_seen = 1;
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected actual write=%0b addr=%h required no command", app_cmd_write, app_addr);
            end else begin
                cmd_t e;
                e = exp_cmd.pop_front();
                if ({app_cmd_write, app_addr, app_wdata} !== {e.w, e.a, e.d}) begin
                    errors++;
                    $display("FAIL cmd actual w=%0b a=%h d=%h required w=%0b a=%h d=%h",
                             app_cmd_write, app_addr, app_wdata, e.w, e.a, e.d);
                end
            end
        end
        if (write_into_read_out_fifo) begin
            pushes++;
            last_push_cyc = cyc;
            checks++;
            if (exp_push.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected actual data=%h required no push", read_out_fifo_write_data);
            end else begin
                logic [DW-1:0] d;
                d = exp_push.pop_front();
                if (read_out_fifo_write_data !== d) begin
                    errors++;
                    $display("FAIL push_data actual %h required %h", read_out_fifo_write_data, d);
                end
            end
        end
        write_fifo_empty     = (wf_head == wf_tail);
        write_fifo_address   = wf_addr[wf_head % 16];
        write_fifo_data      = wf_data[wf_head % 16];
        read_in_fifo_empty   = (rf_head == rf_tail);
        read_in_fifo_address = rf_addr[rf_head % 16];
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input string name);
        int n;
        n = 0;
        hs_seen = 0;
        while (!hs_seen && n < 20) begin step(); n++; end
        checks++;
        if (!hs_seen) begin
            errors++;
            $display("FAIL %s_handshake actual none required handshake within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        int n;
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({read_from_write_fifo, read_from_read_in_fifo, write_into_read_out_fifo, app_cmd_valid,
             app_cmd_write, busy, timeout_error, app_addr, app_wdata, read_out_fifo_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_initial actual valid=%0b busy=%0b addr=%h required all zero", app_cmd_valid, busy, app_addr);
        end
        @(posedge clk); #1 reset = 1'b0;
        app_ready = 1'b0;
        add_write(32'h0000_2008, {4{32'h1357_9BDF}});
        n = 0;
        while (!app_cmd_valid && n < 10) begin step(); n++; end
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({read_from_write_fifo, app_cmd_valid, app_cmd_write, busy, app_addr, app_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_async actual valid=%0b busy=%0b addr=%h required all zero", app_cmd_valid, busy, app_addr);
        end
        @(posedge clk); #1 reset = 1'b0;
        exp_cmd.delete();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle actual busy=%0b required 0", busy);
        end
    endtask

    task automatic test_single_write();
        int wp0, vc0, bc0;
        wp0 = wr_pops; vc0 = valid_cycles; bc0 = busy_cycles;
        app_ready = 1'b1;
        add_write(32'h0000_1234, 128'hAAAAAAAA_AAAAAAAA_55555555_55555555);
        repeat (8) step();
        checks++;
        if (wr_pops - wp0 != 1) begin errors++; $display("FAIL write_pop_count actual %0d required 1", wr_pops - wp0); end
        checks++;
        if (valid_cycles - vc0 != 1) begin errors++; $display("FAIL write_valid_cycles actual %0d required 1", valid_cycles - vc0); end
        checks++;
        if (busy_cycles - bc0 != 1) begin errors++; $display("FAIL write_busy_cycles actual %0d required 1", busy_cycles - bc0); end
        checks++;
        if (exp_cmd.size() != 0) begin errors++; $display("FAIL write_cmd_pending actual %0d required 0", exp_cmd.size()); end
    endtask

    task automatic test_back_to_back();
        int wp0, vc0;
        wp0 = wr_pops; vc0 = valid_cycles;
        app_ready = 1'b1;
        add_write(32'h0000_3001, {4{32'h0102_0304}});
        add_write(32'h0000_3017, {4{32'h1112_1314}});
        add_write(32'h0000_302F, {4{32'h2122_2324}});
        repeat (12) step();
        checks++;
        if (wr_pops - wp0 != 3) begin errors++; $display("FAIL b2b_pop_count actual %0d required 3", wr_pops - wp0); end
        checks++;
        if (valid_cycles - vc0 != 3) begin errors++; $display("FAIL b2b_valid_cycles actual %0d required 3", valid_cycles - vc0); end
        checks++;
        if (exp_cmd.size() != 0) begin errors++; $display("FAIL b2b_cmd_pending actual %0d required 0", exp_cmd.size()); end
    endtask

    task automatic test_refill_delay();
        int rp0, vc0, pu0, n, rdata_cyc;
        logic [DW-1:0] d;
        rp0 = rd_pops; vc0 = valid_cycles; pu0 = pushes;
        d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        app_ready = 1'b0;
        read_out_fifo_full = 1'b0;
        add_read(32'h0000_0040);
        n = 0;
        while (!app_cmd_valid && n < 10) begin step(); n++; end
        step();
        step();
        app_ready = 1'b1;
        step();
        app_ready = 1'b0;
        step();
        step();
        app_rdata_valid = 1'b1;
        app_rdata = d;
        exp_push.push_back(d);
        rdata_cyc = cyc + 1;
        step();
        app_rdata_valid = 1'b0;
        app_rdata = '0;
        repeat (3) step();
        checks++;
        if (valid_cycles - vc0 != 3) begin errors++; $display("FAIL refill_valid_cycles actual %0d required 3", valid_cycles - vc0); end
        checks++;
        if (rd_pops - rp0 != 1) begin errors++; $display("FAIL refill_pop_count actual %0d required 1", rd_pops - rp0); end
        checks++;
        if (pushes - pu0 != 1) begin errors++; $display("FAIL refill_push_count actual %0d required 1", pushes - pu0); end
        checks++;
        if (last_push_cyc != rdata_cyc + 1) begin
            errors++; $display("FAIL refill_push_latency actual cycle %0d required %0d", last_push_cyc, rdata_cyc + 1);
        end
    endtask

    task automatic test_priority();
        int rp0, pu0;
        logic [DW-1:0] d;
        rp0 = rd_pops; pu0 = pushes;
        d = {4{32'h600D_DA7A}};
        app_ready = 1'b1;
        read_out_fifo_full = 1'b1;
        add_write(32'h0000_5555, {4{32'hF0F0_0F0F}});
        add_read(32'h0000_5555);
        repeat (10) step();
        checks++;
        if (rd_pops != rp0) begin errors++; $display("FAIL prio_read_while_full actual pops=%0d required 0", rd_pops - rp0); end
        checks++;
        if (exp_cmd.size() != 1) begin errors++; $display("FAIL prio_write_first actual pending=%0d required 1", exp_cmd.size()); end
        read_out_fifo_full = 1'b0;
        wait_hs("prio_read");
        checks++;
        if (rd_pops - rp0 != 1) begin errors++; $display("FAIL prio_read_pop actual %0d required 1", rd_pops - rp0); end
        app_rdata_valid = 1'b1;
        app_rdata = d;
        exp_push.push_back(d);
        step();
        app_rdata_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (pushes - pu0 != 1) begin errors++; $display("FAIL prio_push_count actual %0d required 1", pushes - pu0); end
    endtask

    task automatic test_push_backpressure();
        int pu0, fall_cyc;
        logic [DW-1:0] d;
        d = 128'h0BADC0DE_11223344_55667788_99AABBCC;
        app_ready = 1'b1;
        read_out_fifo_full = 1'b0;
        add_read(32'h0000_0085);
        wait_hs("bp_read");
        read_out_fifo_full = 1'b1;
        app_rdata_valid = 1'b1;
        app_rdata = d;
        exp_push.push_back(d);
        step();
        app_rdata_valid = 1'b0;
        app_rdata = {4{32'hFFFF_FFFF}};
        pu0 = pushes;
        repeat (4) step();
        checks++;
        if (pushes != pu0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_hold actual pushes=%0d busy=%0b required 0 and 1", pushes - pu0, busy);
        end
        read_out_fifo_full = 1'b0;
        fall_cyc = cyc + 1;
        repeat (3) step();
        checks++;
        if (pushes - pu0 != 1) begin errors++; $display("FAIL bp_push_count actual %0d required 1", pushes - pu0); end
        checks++;
        if (last_push_cyc != fall_cyc + 1) begin
            errors++; $display("FAIL bp_push_latency actual cycle %0d required %0d", last_push_cyc, fall_cyc + 1);
        end
    endtask

    task automatic test_timeout();
        int pu0, hs_cyc, te_cyc, n;
        pu0 = pushes;
        app_ready = 1'b1;
        add_read(32'h0000_00C4);
        wait_hs("to_read");
        hs_cyc = cyc;
        n = 0;
        while (!timeout_error && n < 60) begin step(); n++; end
        te_cyc = cyc + 1;
        checks++;
        if (timeout_error !== 1'b1) begin
            errors++; $display("FAIL timeout_flag actual %0b required 1 within 60 cycles", timeout_error);
        end
        checks++;
        if (te_cyc < hs_cyc + TO + 1 || te_cyc > hs_cyc + TO + 2) begin
            errors++; $display("FAIL timeout_delay actual %0d required %0d..%0d", te_cyc - hs_cyc, TO + 1, TO + 2);
        end
        repeat (5) step();
        checks++;
        if (timeout_error !== 1'b1 || busy !== 1'b0 || pushes != pu0) begin
            errors++; $display("FAIL timeout_sticky actual err=%0b busy=%0b pushes=%0d required 1 0 0", timeout_error, busy, pushes - pu0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int pu0;
        pu0 = pushes;
        app_ready = 1'b1;
        add_read(32'h0000_0104);
        wait_hs("rst_read");
        step();
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (timeout_error !== 1'b0 || busy !== 1'b0 || app_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid actual err=%0b busy=%0b valid=%0b required 0 0 0", timeout_error, busy, app_cmd_valid);
        end
        @(posedge clk); #1 reset = 1'b0;
        app_ready = 1'b0;
        app_rdata_valid = 1'b1;
        app_rdata = {4{32'h5757_5757}};
        step();
        app_rdata_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (pushes != pu0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_stray_rdata actual pushes=%0d busy=%0b required 0 0", pushes - pu0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_refill_delay();
        test_priority();
        test_push_backpressure();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual still running required finish");
        $fatal(1, "watchdog");
    end

endmodule
